sd_decimator: RTL and testbench
===============================

# sd_decimator

Third-order CIC decimator that converts a 1-bit sigma-delta stream back into 16-bit Q(1,15) PCM samples. It is the receive-side counterpart of the second-order sigma-delta DAC: it feeds a DAC bitstream (or an external modulator's) into loopback benches and measurement paths. Output samples use a single-entry valid/ready holding register with overrun signalling.

## Interface
- LOG2R, default 6: log2 of the decimation ratio R = 2^LOG2R; legal range 5..10.
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- sd_in  input  1  sigma-delta bit; 1 = +1, 0 = -1.
- bit_valid  input  1  sd_in is consumed on every edge where bit_valid = 1.
- pcm_out  output  16  signed decimated sample, Q(1,15).
- pcm_valid  output  1  pcm_out holds an unconsumed sample.
- pcm_ready  input  1  consumer accepts the sample on an edge where pcm_valid & pcm_ready.
- overrun  output  1  one-cycle pulse: an unconsumed sample was overwritten.

## Operation
- Width W = 2 + 3*LOG2R (20 for the default).
- Three integrators of W bits, two's-complement wrap-around. No saturation is allowed in the integrators.
  - Each integrator updates only on bit_valid.
  - i1 += x, where x = +1/-1.
  - i2 += i1_new.
  - i3 += i2_new.
- Decimation counter dcnt, LOG2R bits, increments on bit_valid and wraps R-1 -> 0.
  - The edge consuming a bit with dcnt = R-1 is the decimation strobe D.
  - At D, i3_new is captured into the comb pipeline.
- Comb pipeline: three differentiators, delay 1 (in decimated samples), W-bit wrap-around, one register stage each.
  - c1 = s - s_prev.
  - c2 = c1 - c1_prev.
  - c3 = c2 - c2_prev.
  - The "prev" registers update only when their stage receives a new sample.
- Output scaling: y = c3 >>> (3*LOG2R - 15), arithmetic shift.
  - Saturate y to [-32768, 32767]. Full-scale +1 input gives +2^(3*LOG2R) and maps to 0x7FFF; full-scale -1 maps to 0x8000.
- Warm-up: after reset, the first 3 comb outputs are discarded. A 2-bit warm-up counter saturates at 3. The 4th and later outputs are delivered.
- Holding register:
  - A delivered sample loads pcm_out and sets pcm_valid.
  - pcm_valid clears on an edge with pcm_valid & pcm_ready and no simultaneous new sample.
  - New sample together with acceptance in the same cycle: load the new sample, pcm_valid stays 1, no overrun.
  - New sample while pcm_valid = 1 and pcm_ready = 0: overwrite pcm_out, pcm_valid stays 1, overrun = 1 for exactly one cycle.
- Reset (rst_n = 0 on an edge):
  - Clears integrators, combs, prev registers, dcnt, warm-up counter, and the pipeline valid bits.
  - pcm_out = 0, pcm_valid = 0, overrun = 0.
  - Reset mid-frame discards the partial frame and any in-flight comb samples. The next frame starts with the first bit after reset release, and warm-up restarts.

## Timing
- Latency: pcm_out/pcm_valid update on the 4th rising edge after strobe D (D+1 c1, D+2 c2, D+3 c3, D+4 output register).
- The latency is independent of bit_valid gaps. bit_valid may be high every cycle or sparse, and the comb pipeline advances every clock.
- One output per R consumed bits. With bit_valid continuous, the output period is exactly R cycles.
- overrun is asserted during the cycle after the offending load edge, together with the new pcm_out.
- No combinational path from any input to any output.

## Test plan
- Reset check: reset asserted, then sd_in = 1 continuous with bit_valid = 1, pcm_ready = 1, LOG2R = 6.
  - During reset: outputs 0.
  - No pcm_valid before the 4th strobe; every sample after that is 0x7FFF, period 64 cycles.
  - First valid sample appears exactly 4 edges after the strobe of bit 256.
- Negative full scale: sd_in = 0 continuous -> every delivered sample is 0x8000.
- Zero mean: sd_in alternating 1,0 -> 0x0000.
- Positive half scale: repeating pattern 1,1,1,0 -> 0x4000 (+0.5).
  - Also repeat with bit_valid high one cycle in three: same values, output period 192 cycles.
- Backpressure and reset:
  - Hold pcm_ready = 0 across two strobes -> the second sample overwrites, overrun pulses for one cycle, pcm_valid stays 1.
  - Raise pcm_ready on the same cycle a new sample arrives -> no overrun.
  - Assert rst_n = 0 for one cycle mid-frame -> outputs clear and warm-up restarts.
- Loopback: the sigma-delta DAC driven with constant 0x2000 (0.25) feeds sd_in. After settling, delivered samples have a mean of 0x2000 ±64 over 32 samples, and no sample is saturated.

Source files
------------

// File: rtl/sd_decimator.sv
// Third-order CIC decimator: 1-bit sigma-delta stream in, saturated Q(1,15) PCM out
// through a single-entry valid/ready holding register that flags overwrites.
module sd_decimator #(
  parameter int LOG2R = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sd_in,
  input  logic               bit_valid,
  output logic signed [15:0] pcm_out,
  output logic               pcm_valid,
  input  logic               pcm_ready,
  output logic               overrun
);

  localparam int W  = 2 + 3 * LOG2R;
  localparam int SH = 3 * LOG2R - 15;
  localparam logic signed [W-1:0] PLUS_ONE  = W'(1);
  localparam logic signed [W-1:0] MINUS_ONE = '1;
  localparam logic [LOG2R-1:0]    DCNT_LAST = '1;

  logic signed [W-1:0] i1_reg, i2_reg, i3_reg;
  logic signed [W-1:0] i1_next, i2_next, i3_next;
  logic [LOG2R-1:0]    dcnt_reg;
  logic                strobe;

  // stage_reg[0] is the captured integrator sample, stage_reg[1..3] are c1..c3
  logic signed [W-1:0] stage_reg [4];
  logic signed [W-1:0] prev_reg  [3];
  logic signed [W-1:0] diff      [3];
  logic [3:0]          vld_reg;
  logic [1:0]          warm_reg;

  logic signed [16:0]  y_shift;
  logic signed [15:0]  y_sat;
  logic                deliver;

  always_comb begin
    i1_next = i1_reg + (sd_in ? PLUS_ONE : MINUS_ONE);
    i2_next = i2_reg + i1_next;
    i3_next = i3_reg + i2_next;
  end

  assign strobe = bit_valid && (dcnt_reg == DCNT_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_comb
      assign diff[gi] = stage_reg[gi] - prev_reg[gi];
    end
  endgenerate

  // After the shift only 17 significant bits remain; clip the top one away.
  always_comb begin
    y_shift = 17'(stage_reg[3] >>> SH);
    if (y_shift[16] != y_shift[15]) begin
      y_sat = y_shift[16] ? 16'sh8000 : 16'sh7FFF;
    end else begin
      y_sat = y_shift[15:0];
    end
  end

  assign deliver = vld_reg[3] && (warm_reg == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i1_reg    <= '0;
      i2_reg    <= '0;
      i3_reg    <= '0;
      dcnt_reg  <= '0;
      vld_reg   <= '0;
      warm_reg  <= '0;
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int k = 0; k < 4; k++) stage_reg[k] <= '0;
      for (int k = 0; k < 3; k++) prev_reg[k] <= '0;
    end else begin
      if (bit_valid) begin
        i1_reg   <= i1_next;
        i2_reg   <= i2_next;
        i3_reg   <= i3_next;
        dcnt_reg <= dcnt_reg + LOG2R'(1);
      end

      // Comb pipeline advances every clock, independent of bit_valid gaps.
      vld_reg <= {vld_reg[2:0], strobe};
      if (strobe) stage_reg[0] <= i3_next;
      for (int k = 0; k < 3; k++) begin
        if (vld_reg[k]) begin
          stage_reg[k+1] <= diff[k];
          prev_reg[k]    <= stage_reg[k];
        end
      end

      if (vld_reg[3] && (warm_reg != 2'd3)) warm_reg <= warm_reg + 2'd1;

      overrun <= deliver && pcm_valid && !pcm_ready;
      if (deliver) begin
        pcm_out   <= y_sat;
        pcm_valid <= 1'b1;
      end else if (pcm_valid && pcm_ready) begin
        pcm_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sd_decimator.sv
// Bench for sd_decimator: convolution-based CIC reference with a latency scoreboard,
// table-driven pattern rows, backpressure/reset sequences, random and loopback stimulus.
module tb_sd_decimator;

  localparam int LOG2R = 6;
  localparam int R     = 1 << LOG2R;
  localparam int SH    = 3 * LOG2R - 15;
  localparam int HL    = 3 * R - 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sd_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        pcm_ready = 1'b0;
  logic [15:0] pcm_out;
  logic        pcm_valid;
  logic        overrun;

  sd_decimator #(.LOG2R(LOG2R)) dut (
    .clk(clk), .rst_n(rst_n), .sd_in(sd_in), .bit_valid(bit_valid),
    .pcm_out(pcm_out), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int val; int idx; } pend_t;
  typedef struct { logic [3:0] pat; int plen; int gap; logic [15:0] exp_val; } row_t;

  pend_t       pend[$];
  int          hist[$];
  int          h[HL];
  int          cyc = 0, nbits = 0, nstrobe = 0, strobe4_cyc = -1;
  int          n_tests = 0, n_fail = 0, n_deliv = 0;
  bit          exp_valid = 0, exp_ovr = 0, deliv_now = 0;
  logic [15:0] exp_out = '0;

  // Reference output: impulse response of three cascaded length-R boxcars
  // applied to the bit history since reset, then scaled and clipped.
  function automatic int cic_ref();
    longint acc = 0;
    int n = hist.size();
    for (int j = 0; j < HL; j++) if (j < n) acc += longint'(h[j]) * hist[n-1-j];
    acc = acc >>> SH;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    pend_t p;
    cyc++;
    deliv_now = 0;
    if (!rst_n) begin
      hist.delete(); pend.delete();
      nbits = 0; nstrobe = 0; strobe4_cyc = -1;
      exp_valid = 0; exp_ovr = 0; exp_out = '0;
      return;
    end
    exp_ovr = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      if (p.idx >= 4) begin
        deliv_now = 1;
        exp_ovr   = exp_valid && !pcm_ready;
        exp_out   = 16'(p.val);
        exp_valid = 1;
        n_deliv++;
      end
    end
    if (!deliv_now && exp_valid && pcm_ready) exp_valid = 0;
    if (bit_valid) begin
      hist.push_back(sd_in ? 1 : -1);
      if (hist.size() > HL) void'(hist.pop_front());
      nbits++;
      if (nbits % R == 0) begin
        nstrobe++;
        p.due = cyc + 4; p.val = cic_ref(); p.idx = nstrobe;
        pend.push_back(p);
        if (nstrobe == 4) strobe4_cyc = cyc;
      end
    end
  endtask

  task automatic tick(input bit b, input bit bv, input bit rdy);
    sd_in = b; bit_valid = bv; pcm_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check("pcm_valid", pcm_valid, exp_valid);
    check("overrun", overrun, exp_ovr);
    check("pcm_out", pcm_out, exp_out);
    if (deliv_now)
      $display("[TB] cyc=%0d sample=%0d pcm_out=%04h overrun=%b", cyc, n_deliv, pcm_out, overrun);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      check("reset_pcm_valid", pcm_valid, 0);
      check("reset_pcm_out", pcm_out, 0);
      check("reset_overrun", overrun, 0);
    end
    rst_n = 1'b1;
  endtask

  task automatic run_row(input row_t r);
    int consumed = 0, seen = 0, last_v = -1, first_v = -1;
    int budget = 13 * R * r.gap + 20;
    bit bv;
    do_reset(3);
    for (int c = 0; c < budget && seen < 8; c++) begin
      bv = (c % r.gap) == 0;
      tick(r.pat[consumed % r.plen], bv, 1'b1);
      if (bv) consumed++;
      if (pcm_valid) begin
        seen++;
        check("row_value", pcm_out, r.exp_val);
        if (first_v < 0) begin
          first_v = cyc;
          check("first_valid_latency", cyc, strobe4_cyc + 4);
        end else begin
          check("row_period", cyc - last_v, R * r.gap);
        end
        last_v = cyc;
      end
    end
    check("row_sample_count", seen, 8);
  endtask

  row_t rows[5];
  int   v1, v2, d0, held, ovr_cnt, sum, dev, seen;
  bit   b, rdy, mb;

  initial begin
    for (int i = 0; i < HL; i++) h[i] = 0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < R; j++)
        for (int k = 0; k < R; k++) h[i+j+k] += 1;

    rows[0] = '{4'b0001, 1, 1, 16'h7FFF};
    rows[1] = '{4'b0000, 1, 1, 16'h8000};
    rows[2] = '{4'b0001, 2, 1, 16'h0000};
    rows[3] = '{4'b0111, 4, 1, 16'h4000};
    rows[4] = '{4'b0111, 4, 3, 16'h4000};
    for (int i = 0; i < 5; i++) run_row(rows[i]);

    // Backpressure: overwrite while held, then acceptance coinciding with a load.
    do_reset(2);
    d0 = n_deliv;
    for (int c = 0; c < 6 * R && n_deliv == d0; c++) tick($urandom_range(0, 3) != 0, 1'b1, 1'b1);
    check("bp_first_delivery", n_deliv - d0, 1);
    tick($urandom_range(0, 3) != 0, 1'b1, 1'b1);
    d0 = n_deliv; ovr_cnt = 0;
    for (int c = 0; c < 3 * R && n_deliv - d0 < 2; c++) begin
      tick($urandom_range(0, 3) != 0, 1'b1, 1'b0);
      if (overrun) ovr_cnt++;
      if (n_deliv > d0) check("bp_hold_valid", pcm_valid, 1);
    end
    for (int c = 0; c < 3; c++) begin
      tick($urandom_range(0, 3) != 0, 1'b1, 1'b0);
      if (overrun) ovr_cnt++;
      check("bp_hold_valid", pcm_valid, 1);
    end
    check("bp_overrun_pulses", ovr_cnt, 1);
    d0 = n_deliv;
    for (int c = 0; c < 2 * R && n_deliv == d0; c++) begin
      rdy = pend.size() > 0 && pend[0].due == cyc + 1 && pend[0].idx >= 4;
      tick($urandom_range(0, 3) != 0, 1'b1, rdy);
    end
    check("sim_accept_delivery", n_deliv - d0, 1);
    check("sim_accept_no_overrun", overrun, 0);
    check("sim_accept_valid", pcm_valid, 1);
    tick(1'b1, 1'b1, 1'b1);
    check("accept_clears_valid", pcm_valid, 0);

    // Mid-frame reset with a comb sample in flight and a held sample.
    for (int c = 0; c < 4 * R && !(nstrobe >= 5 && pend.size() > 0); c++)
      tick($urandom_range(0, 1) != 0, 1'b1, 1'b0);
    check("midreset_inflight", pend.size() > 0, 1);
    rst_n = 1'b0;
    tick(1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    check("midreset_valid_clear", pcm_valid, 0);
    check("midreset_out_clear", pcm_out, 0);
    seen = 0;
    for (int c = 0; c < 5 * R + 20 && !pcm_valid; c++) begin
      tick(1'b1, 1'b1, 1'b1);
      if (pcm_valid) begin
        seen = 1;
        check("midreset_latency", cyc, strobe4_cyc + 4);
        check("midreset_value", pcm_out, 16'h7FFF);
      end
    end
    check("midreset_first_sample", seen, 1);

    // Random density blocks with random gaps and backpressure.
    do_reset(2);
    for (int blk = 0; blk < 16; blk++) begin
      int p = $urandom_range(0, 100);
      for (int c = 0; c < 200; c++)
        tick($urandom_range(0, 99) < p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);
    end

    // Loopback from a second-order modulator driven with 0.25.
    do_reset(2);
    v1 = 0; v2 = 0; seen = 0; sum = 0;
    for (int c = 0; c < 45 * R && seen < 40; c++) begin
      mb = v2 >= 0;
      tick(mb, 1'b1, 1'b1);
      v1 += 8192 - (mb ? 32768 : -32768);
      v2 += v1 - (mb ? 32768 : -32768);
      if (pcm_valid) begin
        seen++;
        if (seen > 8) begin
          sum += int'($signed(pcm_out));
          check("loop_no_saturation", pcm_out == 16'h7FFF || pcm_out == 16'h8000, 0);
        end
      end
    end
    check("loop_sample_count", seen, 40);
    dev = sum - 32 * 8192;
    if (dev < 0) dev = -dev;
    n_tests++;
    if (dev > 32 * 64) begin
      n_fail++;
      $display("FAIL loop_mean actual=%0d required=8192+-64", sum / 32);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
